// File: rtl/prefetch_queue_if.sv
// Bus bundle for prefetch_queue: memory fetch port, decoder-side queue port and redirect inputs.
// The master modport is the prefetch queue itself; slave is the surrounding core/memory.
interface prefetch_queue_if #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [SIZE-1:0] RST_VEC;
    logic [SIZE-1:0] MAB_out;
    logic            mem_req;
    logic            mem_ack;
    logic [SIZE-1:0] MDB_out;
    logic [SIZE-1:0] instr_out;
    logic [SIZE-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_pop;
    logic            flush;
    logic [SIZE-1:0] flush_pc;
    logic [CW-1:0]   count;

    modport master (
        input  RST_VEC, mem_ack, MDB_out, instr_pop, flush, flush_pc,
        output MAB_out, mem_req, instr_out, instr_pc, instr_valid, count
    );

    modport slave (
        output RST_VEC, mem_ack, MDB_out, instr_pop, flush, flush_pc,
        input  MAB_out, mem_req, instr_out, instr_pc, instr_valid, count
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit-aligned words into a DEPTH-entry FIFO for the decoder.
// Optional PREFETCH_BYPASS_EN forwards an ack straight to the decoder when the queue is empty.
module prefetch_queue #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    prefetch_queue_if.master bus
);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [SIZE-1:0] mab_q, mab_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [SIZE-1:0] data_q [DEPTH];
    logic [SIZE-1:0] pc_q   [DEPTH];

    logic            accept, push, pop, bypass;
    logic [SIZE-1:0] flush_pc_al, rst_vec_al;

    assign flush_pc_al = bus.flush_pc & ~SIZE'(1);
    assign rst_vec_al  = bus.RST_VEC & ~SIZE'(1);

    // Only an ack to a live (non-discarded) request carries data we keep.
    assign accept = (state_q == StReq) && bus.mem_ack && !bus.flush;
`ifdef PREFETCH_BYPASS_EN
    assign bypass = accept && (count_q == '0) && bus.instr_pop;
`else
    assign bypass = 1'b0;
`endif
    assign push = accept && !bypass;
    assign pop  = bus.instr_pop && (count_q != '0) && !bus.flush;

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mab_d      = mab_q;
        case (state_q)
            StIdle: begin
                if (bus.flush) begin
                    state_d    = StReq;
                    fetch_pc_d = flush_pc_al;
                end else if (count_d < FULL) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.flush) begin
                    fetch_pc_d = flush_pc_al;
                    // The outstanding request must still finish at its own address.
                    if (!bus.mem_ack) begin
                        state_d = StDiscard;
                        mab_d   = fetch_pc_q;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_d = fetch_pc_q + SIZE'(2);
                    state_d    = (count_d < FULL) ? StReq : StIdle;
                end
            end
            StDiscard: begin
                if (bus.flush) begin
                    fetch_pc_d = flush_pc_al;
                end
                if (bus.mem_ack) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= rst_vec_al;
            mab_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mab_q      <= mab_d;
            count_q    <= count_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.MDB_out;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    always_comb begin
        bus.instr_valid = 1'b0;
        bus.instr_out   = '0;
        bus.instr_pc    = '0;
        if (count_q != '0) begin
            bus.instr_valid = 1'b1;
            bus.instr_out   = data_q[rd_ptr_q];
            bus.instr_pc    = pc_q[rd_ptr_q];
        end
`ifdef PREFETCH_BYPASS_EN
        else if (accept) begin
            bus.instr_valid = 1'b1;
            bus.instr_out   = bus.MDB_out;
            bus.instr_pc    = fetch_pc_q;
        end
`endif
    end

    assign bus.MAB_out = rst ? rst_vec_al : ((state_q == StDiscard) ? mab_q : fetch_pc_q);
    assign bus.mem_req = (state_q != StIdle);
    assign bus.count   = count_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: stimulus queues expected {word, pc} pairs,
// a negedge monitor checks every word the decoder side consumes.
module tb_prefetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prefetch_queue_if #(.SIZE(16), .DEPTH(4)) bus ();

    prefetch_queue #(.SIZE(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [15:0] pc);
        exp_t e;
        e.data = d;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every consumed word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_pop) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got %h@%h, expected no word", bus.instr_out,
                         bus.instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_data", 32'(bus.instr_out), 32'(e.data));
                check("sb_pc", 32'(bus.instr_pc), 32'(e.pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RST_VEC   = 16'hC001;
        bus.mem_ack   = 1'b0;
        bus.MDB_out   = '0;
        bus.instr_pop = 1'b0;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        tick();
        tick();

        // Reset state
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mab", 32'(bus.MAB_out), 32'hC000);
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_out", 32'(bus.instr_out), 32'h0);
        check("rst_pc", 32'(bus.instr_pc), 32'h0);

        rst = 1'b0;
        tick();
        check("first_req", 32'(bus.mem_req), 32'h1);
        check("first_mab", 32'(bus.MAB_out), 32'hC000);

        // Two fetches, then drain
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'h4031;
        expect_word(16'h4031, 16'hC000);
        #1;
`ifdef PREFETCH_BYPASS_EN
        check("bypass_valid", 32'(bus.instr_valid), 32'h1);
`else
        check("no_bypass_valid", 32'(bus.instr_valid), 32'h0);
`endif
        tick();
        check("push_valid", 32'(bus.instr_valid), 32'h1);
        check("push_out", 32'(bus.instr_out), 32'h4031);
        bus.MDB_out = 16'h0280;
        expect_word(16'h0280, 16'hC002);
        tick();
        bus.mem_ack = 1'b0;
        check("count2", 32'(bus.count), 32'h2);
        bus.instr_pop = 1'b1;
        tick();
        tick();
        bus.instr_pop = 1'b0;
        check("drain_count", 32'(bus.count), 32'h0);
        check("mab_c004", 32'(bus.MAB_out), 32'hC004);

        // Flush while request outstanding; late ack must be dropped
        bus.flush    = 1'b1;
        bus.flush_pc = 16'hE101;
        tick();
        bus.flush = 1'b0;
        check("discard_mab", 32'(bus.MAB_out), 32'hC004);
        check("discard_req", 32'(bus.mem_req), 32'h1);
        tick();
        tick();
        check("discard_mab_stable", 32'(bus.MAB_out), 32'hC004);
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'hAAAA;
        tick();
        bus.mem_ack = 1'b0;
        check("redirect_mab", 32'(bus.MAB_out), 32'hE100);
        check("redirect_count", 32'(bus.count), 32'h0);
        check("redirect_valid", 32'(bus.instr_valid), 32'h0);

        // Fill to DEPTH, fetch stops; one pop restarts it
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.MDB_out = 16'h1111 * 16'(i + 1);
            expect_word(16'h1111 * 16'(i + 1), 16'hE100 + 16'(2 * i));
            tick();
        end
        bus.mem_ack = 1'b0;
        check("full_count", 32'(bus.count), 32'h4);
        check("full_mem_req", 32'(bus.mem_req), 32'h0);
        check("full_mab", 32'(bus.MAB_out), 32'hE108);
        bus.instr_pop = 1'b1;
        tick();
        bus.instr_pop = 1'b0;
        check("restart_req", 32'(bus.mem_req), 32'h1);
        check("restart_mab", 32'(bus.MAB_out), 32'hE108);
        bus.instr_pop = 1'b1;
        tick();
        tick();
        tick();
        bus.instr_pop = 1'b0;
        check("drain2_count", 32'(bus.count), 32'h0);

        // flush + pop + ack with count=2
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'h5555;
        expect_word(16'h5555, 16'hE108);
        tick();
        bus.MDB_out = 16'h6666;
        expect_word(16'h6666, 16'hE10A);
        tick();
        check("pre_flush_count", 32'(bus.count), 32'h2);
        bus.MDB_out   = 16'h7777;
        bus.flush     = 1'b1;
        bus.flush_pc  = 16'h3000;
        bus.instr_pop = 1'b1;
        tick();
        exp_q.delete();
        bus.mem_ack   = 1'b0;
        bus.flush     = 1'b0;
        bus.instr_pop = 1'b0;
        check("flush_count", 32'(bus.count), 32'h0);
        check("flush_valid", 32'(bus.instr_valid), 32'h0);
        check("flush_mab", 32'(bus.MAB_out), 32'h3000);
        check("flush_ack_req", 32'(bus.mem_req), 32'h1);

        // Pop on empty queue is ignored
        bus.instr_pop = 1'b1;
        tick();
        bus.instr_pop = 1'b0;
        check("empty_pop_count", 32'(bus.count), 32'h0);

        // Flush twice while discarding, then land on 0xFFFE
        bus.flush    = 1'b1;
        bus.flush_pc = 16'h1234;
        tick();
        bus.flush_pc = 16'hFFFF;
        tick();
        bus.flush = 1'b0;
        check("discard2_mab", 32'(bus.MAB_out), 32'h3000);
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        check("wrap_start_mab", 32'(bus.MAB_out), 32'hFFFE);
        check("wrap_start_count", 32'(bus.count), 32'h0);

        // Address wrap and DEPTH+1 push/pop pairs
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'hA000;
        expect_word(16'hA000, 16'hFFFE);
        tick();
        check("wrap_mab", 32'(bus.MAB_out), 32'h0000);
        bus.instr_pop = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.MDB_out = 16'hA000 + 16'(i);
            expect_word(16'hA000 + 16'(i), 16'(2 * (i - 1)));
            tick();
            check("pair_count", 32'(bus.count), 32'h1);
        end
        bus.mem_ack = 1'b0;
        tick();
        bus.instr_pop = 1'b0;
        check("pairs_drained", 32'(bus.count), 32'h0);
        check("pairs_mab", 32'(bus.MAB_out), 32'h000A);

        // Empty-queue ack: forwarded with bypass, registered otherwise
        bus.mem_ack = 1'b1;
        bus.MDB_out = 16'hC1C1;
        expect_word(16'hC1C1, 16'h000A);
`ifdef PREFETCH_BYPASS_EN
        bus.instr_pop = 1'b1;
        #1;
        check("bypass_valid2", 32'(bus.instr_valid), 32'h1);
        check("bypass_out", 32'(bus.instr_out), 32'hC1C1);
        check("bypass_pc", 32'(bus.instr_pc), 32'h000A);
        tick();
        bus.mem_ack   = 1'b0;
        bus.instr_pop = 1'b0;
        check("bypass_count", 32'(bus.count), 32'h0);
`else
        #1;
        check("ack_cycle_valid", 32'(bus.instr_valid), 32'h0);
        check("ack_cycle_out", 32'(bus.instr_out), 32'h0);
        tick();
        bus.mem_ack = 1'b0;
        check("latency_count", 32'(bus.count), 32'h1);
        bus.instr_pop = 1'b1;
        tick();
        bus.instr_pop = 1'b0;
        check("latency_drain", 32'(bus.count), 32'h0);
`endif
        check("pre_rst_mab", 32'(bus.MAB_out), 32'h000C);

        // Asynchronous reset mid-request with count=3
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MDB_out = 16'hD001 + 16'(i);
            expect_word(16'hD001 + 16'(i), 16'h000C + 16'(2 * i));
            tick();
        end
        bus.mem_ack = 1'b0;
        check("mid_count3", 32'(bus.count), 32'h3);
        check("mid_req", 32'(bus.mem_req), 32'h1);
        #2;
        bus.RST_VEC = 16'h8000;
        bus.mem_ack = 1'b1;
        rst         = 1'b1;
        #1;
        exp_q.delete();
        check("async_valid", 32'(bus.instr_valid), 32'h0);
        check("async_req", 32'(bus.mem_req), 32'h0);
        check("async_count", 32'(bus.count), 32'h0);
        check("async_out", 32'(bus.instr_out), 32'h0);
        check("async_mab", 32'(bus.MAB_out), 32'h8000);
        tick();
        check("rst_ack_ignored", 32'(bus.count), 32'h0);
        bus.mem_ack = 1'b0;
        rst         = 1'b0;
        tick();
        check("rerun_req", 32'(bus.mem_req), 32'h1);
        check("rerun_mab", 32'(bus.MAB_out), 32'h8000);

        check("sb_leftover", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter SIZE, 16, data/address width in bits.
REQ-002 Parameter DEPTH, 4, queue entries; power of two, at least 2.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port RST_VEC  input  SIZE  fetch start address, sampled while rst is high.
REQ-006 Port MAB_out  output  SIZE  fetch address to memory space.
REQ-007 Port mem_req  output  1  fetch request, registered.
REQ-008 Port mem_ack  input  1  memory completed the request; MDB_out valid this cycle.
REQ-009 Port MDB_out  input  SIZE  fetched instruction word.
REQ-010 Port instr_out  output  SIZE  head-of-queue word to instr_dec.
REQ-011 Port instr_pc  output  SIZE  address of instr_out.
REQ-012 Port instr_valid  output  1  queue head valid.
REQ-013 Port instr_pop  input  1  consumer takes head this cycle.
REQ-014 Port flush  input  1  discard queue and redirect fetch (branch, jump, interrupt).
REQ-015 Port flush_pc  input  SIZE  redirect address.
REQ-016 Port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 FSM states: IDLE (mem_req=0), REQ (mem_req=1), DISCARD (mem_req=1, returned data dropped).
REQ-018 In REQ and DISCARD, MAB_out and mem_req stay stable until a cycle with mem_ack=1.
REQ-019 Transitions: IDLE->REQ when count<DEPTH and flush=0. REQ+ack->REQ if post-update count<DEPTH, else IDLE. REQ+flush+no ack->DISCARD. REQ+flush+ack->REQ with ack data dropped. DISCARD+ack->REQ. IDLE+flush->REQ.
REQ-020 Accepted ack in REQ without flush pushes {MDB_out, fetch_pc} and advances fetch_pc by 2, modulo 2^SIZE (0xFFFE wraps to 0x0000).
REQ-021 flush: queue emptied and fetch_pc loaded with flush_pc with bit 0 forced to 0, both on the next edge.
REQ-022 flush while in DISCARD reloads fetch_pc and stays in DISCARD.
REQ-023 Outstanding request always completes at its original address; that data is never pushed after a flush.
REQ-024 Push is registered: instr_valid rises the cycle after the ack cycle.
REQ-025 Zero-wait memory: one word per cycle when not full.
REQ-026 Pop with count=0 is ignored.
REQ-027 Push and pop in the same cycle leave count unchanged, and the FIFO order of the data is preserved.
REQ-028 flush has priority over a simultaneous pop and push.
REQ-029 Read and write pointers wrap modulo DEPTH.
REQ-030 count never exceeds DEPTH.
REQ-031 A request is issued only when count<DEPTH, so an ack never arrives with the queue full.
REQ-032 instr_out and instr_pc are 0 when instr_valid=0.

Reset
REQ-033 rst=1 asynchronously forces: state IDLE, mem_req 0, count 0, instr_valid 0, queue pointers 0, instr_out 0, instr_pc 0.
REQ-034 While rst=1: fetch_pc = RST_VEC with bit 0 cleared, and MAB_out = fetch_pc.
REQ-035 First mem_req=1 occurs on the first rising edge after rst deasserts.
REQ-036 rst during an outstanding request abandons it; a mem_ack while rst=1 is ignored.

Configuration
REQ-037 Macro PREFETCH_BYPASS_EN.
REQ-038 When defined: with count=0 and an accepted ack in REQ, MDB_out and fetch_pc appear combinationally on instr_out and instr_pc with instr_valid=1 in the same cycle.
REQ-039 Under PREFETCH_BYPASS_EN, a same-cycle instr_pop consumes the word without storing it; otherwise the word is pushed as normal.
REQ-040 When undefined: no combinational path from mem_ack or MDB_out to any output; REQ-024 latency applies.

Verification
REQ-041 RST_VEC=0xC001, release rst -> next edge mem_req=1, MAB_out=0xC000; acks return 0x4031, 0x0280 -> instr_out/instr_pc 0x4031/0xC000 then 0x0280/0xC002.
REQ-042 Ack every cycle, no pops, DEPTH=4 -> count reaches 4, mem_req=0, state IDLE; one pop -> mem_req=1 next cycle at 0xC008.
REQ-043 mem_req=1 at 0xC004, flush with flush_pc=0xE101, ack 3 cycles later carrying 0xAAAA -> 0xAAAA never appears; next request at 0xE100; count 0.
REQ-044 fetch_pc=0xFFFE, ack -> next MAB_out=0x0000; pointers wrap after DEPTH+1 push/pop pairs with data order intact.
REQ-045 Same cycle: flush, pop and ack with count=2 -> count 0 next cycle and acked data dropped; separately, pop with count=0 -> count stays 0.
REQ-046 rst asserted mid-request with count=3 -> instr_valid 0 and mem_req 0 immediately without a clock edge; with PREFETCH_BYPASS_EN, an empty-queue ack shows instr_valid=1 in the same cycle.
